// File: rtl/poci_shift_out_if.sv
// Bus bundle between the POCI shifter and its surroundings (register mux, PICO, pad).
// Only the data/handshake signals live here; sclk and rstn stay plain ports.
interface poci_shift_out_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);

  logic [DATA_W-1:0] read_data;    // register contents at the current address pointer
  logic [7:0]        addr_ptr;     // PICO address pointer
  logic              poci;         // serial data out, MSB first
  logic              poci_oe;      // pad output enable, data phase only
  logic              read_strobe;  // one sclk period after each load
  logic [CNT_W-1:0]  byte_cnt;     // data bytes loaded this transaction, saturating
  logic              busy;         // data phase indicator

  // Environment side: supplies read data and pointer, observes the serial output.
  modport master (
    output read_data,
    output addr_ptr,
    input  poci,
    input  poci_oe,
    input  read_strobe,
    input  byte_cnt,
    input  busy
  );

  // Shifter side.
  modport slave (
    input  read_data,
    input  addr_ptr,
    output poci,
    output poci_oe,
    output read_strobe,
    output byte_cnt,
    output busy
  );

endinterface

// File: rtl/poci_shift_out.sv
// POCI transmit shifter. Byte 0 of a transaction is the address phase; from the first
// byte boundary with a non-zero address pointer onward, every byte shifts out MSB-first
// the register presented on read_data. All flops run on the falling edge of sclk so that
// poci is stable for the controller's rising-edge sample. The only way out of the data
// phase is rstn, which is pulled when sclk stops at the end of a transaction.
module poci_shift_out #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input logic             sclk,
  input logic             rstn,
  poci_shift_out_if.slave bus
);

  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [0:0] {
    StAddr,
    StData
  } state_e;

  state_e              state_q, state_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                strobe_q, strobe_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                at_bb;
  logic                load;

  // Bit counter: free-running within a byte, the last count marks the byte boundary.
  always_comb begin
    at_bb     = (bit_cnt_q == BitLast);
    bit_cnt_d = at_bb ? '0 : bit_cnt_q + BitW'(1);
  end

  // Next state, shift/load of the data register, strobe and saturating byte count.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    load       = 1'b0;
    unique case (state_q)
      StAddr: begin
        // A zero pointer means PICO treats the next byte as another address byte.
        if (at_bb && (bus.addr_ptr != 8'h00)) begin
          load    = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        if (at_bb) begin
          load = 1'b1;
        end else begin
          shreg_d = shreg_q << 1;
        end
      end
      default: begin
        state_d = StAddr;
      end
    endcase
    if (load) begin
      shreg_d = bus.read_data;
    end
    strobe_d   = load;
    byte_cnt_d = byte_cnt_q;
    if (load && (byte_cnt_q != '1)) begin
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  // State register on the falling edge, asynchronous active-low reset.
  always_ff @(negedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StAddr;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      strobe_q   <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      strobe_q   <= strobe_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Outputs decode straight from flops: poci is the register MSB in the data phase,
  // so it only ever moves on a falling edge and drops to idle as soon as rstn asserts.
  always_comb begin
    bus.poci        = (state_q == StData) ? shreg_q[DATA_W-1] : IDLE_LEVEL;
    bus.poci_oe     = (state_q == StData);
    bus.busy        = (state_q == StData);
    bus.read_strobe = strobe_q;
    bus.byte_cnt    = byte_cnt_q;
  end

endmodule

// File: tb/tb_poci_shift_out.sv
// Self-checking bench for poci_shift_out. Two instances share all stimulus: one with the
// default 8-bit byte counter, one with a 2-bit counter to exercise saturation. Expected
// values come from a byte-level transaction model (address phase flag, current byte,
// number of bytes loaded).
module tb_poci_shift_out;

  logic       sclk;
  logic       rstn;
  logic [7:0] read_data;
  logic [7:0] addr_ptr;

  poci_shift_out_if #(.DATA_W(8), .CNT_W(8)) bus8 ();
  poci_shift_out_if #(.DATA_W(8), .CNT_W(2)) bus2 ();

  assign bus8.read_data = read_data;
  assign bus8.addr_ptr  = addr_ptr;
  assign bus2.read_data = read_data;
  assign bus2.addr_ptr  = addr_ptr;

  poci_shift_out #(.DATA_W(8), .IDLE_LEVEL(1'b0), .CNT_W(8)) u_dut8 (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus8)
  );

  poci_shift_out #(.DATA_W(8), .IDLE_LEVEL(1'b0), .CNT_W(2)) u_dut2 (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus2)
  );

  int unsigned n_checks;
  int unsigned n_errors;

  // Transaction model.
  bit         m_data;    // past the address phase
  logic [7:0] m_byte;    // byte currently being shifted out
  int         m_loaded;  // data bytes loaded since reset
  bit         m_strobe;  // load happened at the most recent falling edge

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  // Expected serial bit for bit position i (0 = first bit of the byte).
  function automatic logic exp_bit(input int i);
    logic [7:0] b;
    b = m_byte;
    return m_data ? b[7-i] : 1'b0;
  endfunction

  task automatic check_line(input int i);
    check("poci8", 32'(bus8.poci), 32'(exp_bit(i)));
    check("poci2", 32'(bus2.poci), 32'(exp_bit(i)));
    check("poci_oe", 32'(bus8.poci_oe), 32'(m_data));
  endtask

  task automatic check_status();
    check("read_strobe", 32'(bus8.read_strobe), 32'(m_strobe));
    check("byte_cnt8", 32'(bus8.byte_cnt), sat(m_loaded, 255));
    check("byte_cnt2", 32'(bus2.byte_cnt), sat(m_loaded, 3));
    check("busy", 32'(bus8.busy), 32'(m_data));
    check("busy2", 32'(bus2.busy), 32'(m_data));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_poci"}, 32'(bus8.poci), 32'd0);
    check({tag, "_poci_oe"}, 32'(bus8.poci_oe), 32'd0);
    check({tag, "_byte_cnt"}, 32'(bus8.byte_cnt), 32'd0);
    check({tag, "_busy"}, 32'(bus8.busy), 32'd0);
    check({tag, "_strobe"}, 32'(bus8.read_strobe), 32'd0);
    check({tag, "_byte_cnt2"}, 32'(bus2.byte_cnt), 32'd0);
  endtask

  // One full byte on the wire. PICO updates the pointer on the 8th rising edge, and the
  // register mux presents next_rd then; read_data is scrambled mid-byte to show it is ignored.
  task automatic byte_xfer(input logic [7:0] next_addr, input logic [7:0] next_rd);
    for (int i = 0; i < 8; i++) begin
      check_line(i);
      sclk = 1'b1;
      #2;
      if (i == 3) read_data = 8'($urandom);
      if (i == 7) begin
        addr_ptr  = next_addr;
        read_data = next_rd;
      end
      #3;
      sclk = 1'b0;
      #1;
      m_strobe = 1'b0;
      if (i == 7 && (m_data || next_addr != 8'h00)) begin
        m_data   = 1'b1;
        m_byte   = next_rd;
        m_loaded = m_loaded + 1;
        m_strobe = 1'b1;
      end
      check_status();
      #4;
    end
  endtask

  task automatic reset_now(input string tag);
    rstn = 1'b0;
    #1;
    check_idle(tag);
    m_data   = 1'b0;
    m_loaded = 0;
    m_strobe = 1'b0;
    #2;
    rstn = 1'b1;
    #2;
  endtask

  // n bits of the current byte, optional clock stall, then reset right after the next rise.
  task automatic partial_reset(input int n, input bit stall, input string tag);
    for (int i = 0; i < n; i++) begin
      check_line(i);
      sclk = 1'b1;
      #5;
      sclk = 1'b0;
      #1;
      m_strobe = 1'b0;
      check_status();
      #4;
    end
    if (stall) begin
      #200;
      check_line(n);
      check_status();
    end
    check_line(n);
    sclk = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check_idle(tag);
    #2;
    sclk = 1'b0;
    #2;
    m_data   = 1'b0;
    m_loaded = 0;
    m_strobe = 1'b0;
    rstn = 1'b1;
    #3;
  endtask

  initial begin
    logic [7:0] a;
    n_checks  = 0;
    n_errors  = 0;
    sclk      = 1'b0;
    rstn      = 1'b0;
    read_data = 8'h00;
    addr_ptr  = 8'h00;
    m_data    = 1'b0;
    m_byte    = 8'h00;
    m_loaded  = 0;
    m_strobe  = 1'b0;
    #5;
    check_idle("por");
    rstn = 1'b1;
    #5;

    // Single read 0xA5 at address 0x05.
    byte_xfer(8'h05, 8'hA5);
    byte_xfer(8'h06, 8'($urandom));
    reset_now("rst_after_single");

    // Burst 0x3C, 0xFF, 0x00 from address 0x10.
    byte_xfer(8'h10, 8'h3C);
    byte_xfer(8'h11, 8'hFF);
    byte_xfer(8'h12, 8'h00);
    byte_xfer(8'h13, 8'($urandom));
    reset_now("rst_after_burst");

    // Null address byte, then real address 0x07.
    byte_xfer(8'h00, 8'($urandom));
    byte_xfer(8'h07, 8'h5A);
    byte_xfer(8'h08, 8'($urandom));
    reset_now("rst_after_null");

    // Reset after rise12 (4 bits into byte 1), with a clock stall first; then 0x81 at 0x02.
    byte_xfer(8'h09, 8'hC3);
    partial_reset(3, 1'b1, "rst_mid_byte");
    byte_xfer(8'h02, 8'h81);
    byte_xfer(8'h03, 8'($urandom));
    reset_now("rst_after_mid");

    // Long burst with pointer wrap 0xFF -> 0x00 while in the data phase; saturates byte_cnt2.
    a = 8'hFD;
    byte_xfer(a, 8'($urandom));
    for (int k = 0; k < 6; k++) begin
      a = a + 8'd1;
      byte_xfer(a, 8'($urandom));
    end
    reset_now("rst_after_wrap");

    // Random transactions, address sometimes zero.
    for (int t = 0; t < 6; t++) begin
      int nb;
      nb = int'($urandom_range(1, 5));
      for (int k = 0; k < nb; k++) begin
        a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        byte_xfer(a, 8'($urandom));
      end
      reset_now("rst_rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
